// File: rtl/hit_resolver_pkg.sv
// hit_resolver_pkg
//   Shared types and defaults for the hit resolver slice.
//   hit_state_t : resolver FSM state (SCAN, KILL, SCORE)
//   HR_*        : default formation/score parameters
//   to_bcd      : converts a decimal constant to packed BCD (up to 8 digits)
package hit_resolver_pkg;

  typedef logic [1:0] hit_state_t;

  localparam hit_state_t SCAN  = 2'd0;
  localparam hit_state_t KILL  = 2'd1;
  localparam hit_state_t SCORE = 2'd2;

  localparam int HR_NUM_ENEMIES   = 55;
  localparam int HR_IDX_W         = 6;
  localparam int HR_SCORE_DIGITS  = 4;
  localparam int HR_SCORE_PER_HIT = 10;

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// hit_resolver_if
//   Bundles the pixel-side hit strobe, the kill handshake and the HUD/bullet
//   outputs of the hit resolver.
//   master : colour mapper / game-state side (drives hit, frame_end, kill_ready)
//   slave  : the resolver itself
interface hit_resolver_if
  import hit_resolver_pkg::*;
#(
  parameter int IDX_W        = HR_IDX_W,
  parameter int SCORE_DIGITS = HR_SCORE_DIGITS
);
  logic                      frame_end;
  logic                      hit;
  logic [IDX_W-1:0]          enemy_idx;
  logic [9:0]                DrawX;
  logic [9:0]                DrawY;
  logic                      kill_valid;
  logic [IDX_W-1:0]          kill_idx;
  logic                      kill_ready;
  logic                      bullet_clear;
  logic [9:0]                hit_x;
  logic [9:0]                hit_y;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                      all_dead;

  modport master (
    output frame_end, hit, enemy_idx, DrawX, DrawY, kill_ready,
    input  kill_valid, kill_idx, bullet_clear, hit_x, hit_y, score_bcd, all_dead
  );

  modport slave (
    input  frame_end, hit, enemy_idx, DrawX, DrawY, kill_ready,
    output kill_valid, kill_idx, bullet_clear, hit_x, hit_y, score_bcd, all_dead
  );
endinterface

// File: rtl/hit_resolver_bcd_digit_add.sv
// bcd_digit_add
//   One BCD digit adder: a_i + b_i + cin_i -> sum_o (BCD) and cout_o.
//   Inputs are assumed to be valid BCD digits (0..9).
module bcd_digit_add (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] raw;

  assign raw    = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
  assign cout_o = (raw > 5'd9);
  // Adding 6 skips the six unused codes and wraps back into 0..9.
  assign sum_o  = cout_o ? 4'(raw + 5'd6) : raw[3:0];
endmodule

// File: rtl/hit_resolver.sv
// hit_resolver
//   Latches the first live enemy hit of each frame and resolves it at frame
//   end: kill handshake to the enemy array, a bullet-clear pulse and a BCD
//   score update performed one digit per cycle with a shared digit adder.
//   Clk   : system clock
//   Reset : synchronous, active-high
//   bus   : hit_resolver_if.slave (hit strobe, pixel position, frame_end,
//           kill handshake, bullet_clear, hit_x/hit_y, score_bcd, all_dead)
module hit_resolver
  import hit_resolver_pkg::*;
#(
  parameter int NUM_ENEMIES   = HR_NUM_ENEMIES,
  parameter int IDX_W         = HR_IDX_W,
  parameter int SCORE_DIGITS  = HR_SCORE_DIGITS,
  parameter int SCORE_PER_HIT = HR_SCORE_PER_HIT
) (
  input logic          Clk,
  input logic          Reset,
  hit_resolver_if.slave bus
);
  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int CNT_W = $clog2(NUM_ENEMIES + 1);
  localparam int DIG_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

  localparam logic [31:0]      SPH_BCD32 = to_bcd(SCORE_PER_HIT);
  localparam logic [SW-1:0]    SPH_BCD   = SPH_BCD32[SW-1:0];
  localparam logic [SW-1:0]    SCORE_MAX = {SCORE_DIGITS{4'h9}};
  localparam logic [CNT_W-1:0] KILLS_ALL = CNT_W'(NUM_ENEMIES);
  localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(SCORE_DIGITS - 1);
  localparam logic [IDX_W:0]   NUM_E     = (IDX_W + 1)'(NUM_ENEMIES);

  hit_state_t             state_q, state_d;
  logic                   pending_q, pending_d;
  logic [IDX_W-1:0]       pend_idx_q, pend_idx_d;
  logic [9:0]             pend_x_q, pend_x_d;
  logic [9:0]             pend_y_q, pend_y_d;
  logic [NUM_ENEMIES-1:0] alive_q, alive_d;
  logic [CNT_W-1:0]       kill_cnt_q, kill_cnt_d;
  logic [9:0]             hit_x_q, hit_x_d;
  logic [9:0]             hit_y_q, hit_y_d;
  logic [SW-1:0]          score_q, score_d;
  logic [DIG_W-1:0]       digit_q, digit_d;
  logic                   carry_q, carry_d;
  logic                   all_dead_q, all_dead_d;

  logic [2**IDX_W-1:0]    alive_ext;
  logic                   capture;
  logic                   kill_vld;
  logic                   handshake;
  logic [3:0]             dig_a, dig_b, dig_sum;
  logic                   dig_cout;

  // Zero-extend the alive mask so any enemy_idx can index it; out-of-range
  // indices read as dead and are dropped.
  always_comb begin
    alive_ext                  = '0;
    alive_ext[NUM_ENEMIES-1:0] = alive_q;
  end

  assign capture   = bus.hit && !pending_q && ({1'b0, bus.enemy_idx} < NUM_E)
                     && alive_ext[bus.enemy_idx];
  assign kill_vld  = (state_q == KILL);
  assign handshake = kill_vld && bus.kill_ready;

  // The single digit adder is steered to the digit selected by digit_q.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (digit_q == i[DIG_W-1:0]) begin
        dig_a = score_q[4*i +: 4];
        dig_b = SPH_BCD[4*i +: 4];
      end
    end
  end

  bcd_digit_add u_bcd (
    .a_i    (dig_a),
    .b_i    (dig_b),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    pend_idx_d = pend_idx_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    alive_d    = alive_q;
    kill_cnt_d = kill_cnt_q;
    hit_x_d    = hit_x_q;
    hit_y_d    = hit_y_q;
    score_d    = score_q;
    digit_d    = digit_q;
    carry_d    = carry_q;
    all_dead_d = all_dead_q;

    if (capture) begin
      pending_d  = 1'b1;
      pend_idx_d = bus.enemy_idx;
      pend_x_d   = bus.DrawX;
      pend_y_d   = bus.DrawY;
    end

    case (state_q)
      SCAN: begin
        // pending_q, not pending_d: a hit on the frame_end cycle waits a frame.
        if (bus.frame_end && pending_q) state_d = KILL;
      end
      KILL: begin
        if (bus.kill_ready) begin
          for (int i = 0; i < NUM_ENEMIES; i++) begin
            if (i[IDX_W-1:0] == pend_idx_q) alive_d[i] = 1'b0;
          end
          kill_cnt_d = kill_cnt_q + 1'b1;
          if (kill_cnt_d == KILLS_ALL) all_dead_d = 1'b1;
          hit_x_d   = pend_x_q;
          hit_y_d   = pend_y_q;
          pending_d = 1'b0;
          digit_d   = '0;
          carry_d   = 1'b0;
          state_d   = SCORE;
        end
      end
      SCORE: begin
        for (int i = 0; i < SCORE_DIGITS; i++) begin
          if (digit_q == i[DIG_W-1:0]) score_d[4*i +: 4] = dig_sum;
        end
        carry_d = dig_cout;
        digit_d = digit_q + 1'b1;
        if (digit_q == LAST_DIG) begin
          // Carry out of the top digit means the score overflowed.
          if (dig_cout) score_d = SCORE_MAX;
          carry_d = 1'b0;
          digit_d = '0;
          state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= SCAN;
      pending_q  <= 1'b0;
      alive_q    <= '1;
      kill_cnt_q <= '0;
      hit_x_q    <= '0;
      hit_y_q    <= '0;
      score_q    <= '0;
      digit_q    <= '0;
      carry_q    <= 1'b0;
      all_dead_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      alive_q    <= alive_d;
      kill_cnt_q <= kill_cnt_d;
      hit_x_q    <= hit_x_d;
      hit_y_q    <= hit_y_d;
      score_q    <= score_d;
      digit_q    <= digit_d;
      carry_q    <= carry_d;
      all_dead_q <= all_dead_d;
    end
  end

  // Captured hit data is only consumed while pending_q is set.
  always_ff @(posedge Clk) begin
    pend_idx_q <= pend_idx_d;
    pend_x_q   <= pend_x_d;
    pend_y_q   <= pend_y_d;
  end

  assign bus.kill_valid   = kill_vld;
  assign bus.kill_idx     = kill_vld ? pend_idx_q : '0;
  assign bus.bullet_clear = handshake;
  assign bus.hit_x        = hit_x_q;
  assign bus.hit_y        = hit_y_q;
  assign bus.score_bcd    = score_q;
  assign bus.all_dead     = all_dead_q;
endmodule
